// File: rtl/mem_ls_stage.sv
// MEM stage: latches EX results, performs one load/store per instruction on a
// req/addr_ok/data_ok bus, extracts load lanes, and feeds WB plus ID forwarding.
module mem_ls_stage #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [5:0]    stall,
    input  logic [31:0]   ex_pc,
    input  logic          ex_mem_en,
    input  logic [3:0]    ex_mem_wen,
    input  logic [AW-1:0] ex_mem_addr,
    input  logic [DW-1:0] ex_mem_wdata,
    input  logic [4:0]    ex_load_sel,
    input  logic          ex_rf_we,
    input  logic [4:0]    ex_rf_waddr,
    input  logic [DW-1:0] ex_result,
    output logic          data_req,
    output logic          data_wr,
    output logic [3:0]    data_wstrb,
    output logic [AW-1:0] data_addr,
    output logic [DW-1:0] data_wdata,
    input  logic          data_addr_ok,
    input  logic          data_data_ok,
    input  logic [DW-1:0] data_rdata,
    output logic          stallreq_for_mem,
    output logic [31:0]   wb_pc,
    output logic          wb_rf_we,
    output logic [4:0]    wb_rf_waddr,
    output logic [DW-1:0] wb_rf_wdata,
    output logic          fwd_we,
    output logic [4:0]    fwd_waddr,
    output logic [DW-1:0] fwd_wdata,
    output logic          fwd_load_pending
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t        state_q;
    logic [31:0]   pc_q;
    logic          mem_en_q;
    logic [3:0]    mem_wen_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [4:0]    load_sel_q;
    logic          rf_we_q;
    logic [4:0]    rf_waddr_q;
    logic [DW-1:0] result_q;
    logic [DW-1:0] rdata_q;

    logic capture;
    logic bubble;
    logic is_load;
    logic [DW-1:0] load_val;

    assign capture = ~stall[3];
    assign bubble  = stall[3] & ~stall[4];
    assign is_load = mem_en_q & (mem_wen_q == 4'b0000);

    // Lane mask bit3 selects lane0 (bits 7:0); unlisted masks read as zero.
    function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [4:0] sel);
        logic [31:0] r;
        r = '0;
        case (sel[3:0])
            4'b1111: r = w;
            4'b1100: r = {{16{sel[4] & w[15]}}, w[15:0]};
            4'b0011: r = {{16{sel[4] & w[31]}}, w[31:16]};
            4'b1000: r = {{24{sel[4] & w[7]}},  w[7:0]};
            4'b0100: r = {{24{sel[4] & w[15]}}, w[15:8]};
            4'b0010: r = {{24{sel[4] & w[23]}}, w[23:16]};
            4'b0001: r = {{24{sel[4] & w[31]}}, w[31:24]};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q       <= '0;
            mem_en_q   <= 1'b0;
            mem_wen_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            load_sel_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            result_q   <= '0;
        end else if (bubble) begin
            pc_q       <= '0;
            mem_en_q   <= 1'b0;
            mem_wen_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            load_sel_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            result_q   <= '0;
        end else if (capture) begin
            pc_q       <= ex_pc;
            mem_en_q   <= ex_mem_en;
            mem_wen_q  <= ex_mem_wen;
            addr_q     <= ex_mem_addr;
            wdata_q    <= ex_mem_wdata;
            load_sel_q <= ex_load_sel;
            rf_we_q    <= ex_rf_we;
            rf_waddr_q <= ex_rf_waddr;
            result_q   <= ex_result;
        end
    end

    // Bus FSM keeps advancing while the stage is held; only a capture or bubble restarts it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else if (bubble) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else if (capture) begin
            state_q <= ex_mem_en ? REQ : IDLE;
            rdata_q <= '0;
        end else begin
            case (state_q)
                REQ: begin
                    if (data_addr_ok) begin
                        if (data_data_ok) begin
                            state_q <= DONE;
                            if (is_load) rdata_q <= data_rdata;
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (data_data_ok) begin
                        state_q <= DONE;
                        if (is_load) rdata_q <= data_rdata;
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    assign data_req   = (state_q == REQ);
    assign data_wr    = |mem_wen_q;
    assign data_wstrb = mem_wen_q;
    assign data_addr  = {addr_q[AW-1:2], 2'b00};
    assign data_wdata = wdata_q;

    assign stallreq_for_mem = (state_q == REQ) | (state_q == RESP);

    assign load_val    = lane_extract(rdata_q, load_sel_q);
    assign wb_pc       = pc_q;
    assign wb_rf_we    = rf_we_q & ~stallreq_for_mem;
    assign wb_rf_waddr = rf_waddr_q;
    assign wb_rf_wdata = is_load ? load_val : result_q;

    assign fwd_we           = rf_we_q;
    assign fwd_waddr        = rf_waddr_q;
    assign fwd_wdata        = wb_rf_wdata;
    assign fwd_load_pending = is_load & rf_we_q & (state_q != DONE);

    logic unused_bits;
    assign unused_bits = ^{stall[5], stall[2:0], addr_q[1:0]};

endmodule

// File: tb/tb_mem_ls_stage.sv
// Bench for mem_ls_stage: directed scenarios then randomized transactions,
// with a scripted bus slave and an arithmetic model of load extraction.
module tb_mem_ls_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  stall;
    logic [31:0] ex_pc;
    logic        ex_mem_en;
    logic [3:0]  ex_mem_wen;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_mem_wdata;
    logic [4:0]  ex_load_sel;
    logic        ex_rf_we;
    logic [4:0]  ex_rf_waddr;
    logic [31:0] ex_result;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        stallreq_for_mem;
    logic [31:0] wb_pc;
    logic        wb_rf_we;
    logic [4:0]  wb_rf_waddr;
    logic [31:0] wb_rf_wdata;
    logic        fwd_we;
    logic [4:0]  fwd_waddr;
    logic [31:0] fwd_wdata;
    logic        fwd_load_pending;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        mem_en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  sel;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] result;
    } instr_t;

    always #5 clk = ~clk;

    mem_ls_stage #(.AW(32), .DW(32)) dut (
        .clk(clk), .resetn(resetn), .stall(stall),
        .ex_pc(ex_pc), .ex_mem_en(ex_mem_en), .ex_mem_wen(ex_mem_wen),
        .ex_mem_addr(ex_mem_addr), .ex_mem_wdata(ex_mem_wdata), .ex_load_sel(ex_load_sel),
        .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .stallreq_for_mem(stallreq_for_mem),
        .wb_pc(wb_pc), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
        .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
        .fwd_load_pending(fwd_load_pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load value from a size/offset view of the mask rather than a per-mask table.
    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [4:0] sel);
        int lo = -1;
        int n = 0;
        bit ok;
        logic [63:0] v, m;
        for (int i = 0; i < 4; i++)
            if (sel[3-i]) begin
                if (lo < 0) lo = i;
                n++;
            end
        ok = (n == 4) || (n == 1) || (n == 2 && (lo % 2 == 0) && sel[2-lo]);
        if (!ok) return 32'h0;
        m = (64'd1 << (8 * n)) - 64'd1;
        v = ({32'h0, w} >> (8 * lo)) & m;
        if (sel[4] && v[8*n-1]) v = v | ~m;
        return v[31:0];
    endfunction

    task automatic drive_ex(input instr_t in);
        ex_pc = in.pc; ex_mem_en = in.mem_en; ex_mem_wen = in.wen;
        ex_mem_addr = in.addr; ex_mem_wdata = in.wdata; ex_load_sel = in.sel;
        ex_rf_we = in.rf_we; ex_rf_waddr = in.waddr; ex_result = in.result;
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_req"}, {31'h0, data_req}, 32'h0);
        chk({pfx, "_stallreq"}, {31'h0, stallreq_for_mem}, 32'h0);
        chk({pfx, "_wb_wdata"}, wb_rf_wdata, 32'h0);
        chk({pfx, "_wb_pc"}, wb_pc, 32'h0);
        chk({pfx, "_bus"}, data_addr | data_wdata | {27'h0, data_wr, data_wstrb}, 32'h0);
        chk({pfx, "_misc"}, {20'h0, wb_rf_we, wb_rf_waddr, fwd_we, fwd_waddr}, 32'h0);
        chk({pfx, "_fwd"}, fwd_wdata | {31'h0, fwd_load_pending}, 32'h0);
    endtask

    // Issue one instruction and act as controller (stall while busy) plus bus slave.
    // addr_ok arrives in REQ cycle a_dly; data_ok arrives d_dly cycles after acceptance.
    task automatic issue(input string tag, input instr_t in, input int a_dly, input int d_dly,
                         input logic [31:0] rdata, input bit noise);
        int k = 0, reqc = 0, stc = 0, bus_bad = 0, wait_bad = 0;
        bit is_load = in.mem_en && (in.wen == 4'b0);
        logic [31:0] exp_wd = is_load ? model_load(rdata, in.sel) : in.result;
        instr_t nop = '0;
        drive_ex(in);
        stall = 6'b000000; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        @(posedge clk); #1;
        drive_ex(nop);
        while (stallreq_for_mem && k < 64) begin
            stall = 6'b011111;
            stc++;
            if (data_req) begin
                reqc++;
                if (data_addr !== {in.addr[31:2], 2'b00} || data_wr !== (in.wen != 4'b0) ||
                    data_wstrb !== in.wen || data_wdata !== in.wdata) bus_bad++;
            end
            if (wb_rf_we !== 1'b0 || fwd_load_pending !== (is_load & in.rf_we)) wait_bad++;
            data_addr_ok = (k == a_dly);
            data_data_ok = (k == a_dly + d_dly) || (noise && k < a_dly && $urandom_range(0, 1) == 1);
            data_rdata   = (k == a_dly + d_dly) ? rdata : $urandom;
            @(posedge clk); #1;
            k++;
        end
        stall = 6'b000000; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        if (k >= 64) chk({tag, "_timeout"}, 32'h1, 32'h0);
        chk({tag, "_stall_cycles"}, stc, in.mem_en ? a_dly + d_dly + 1 : 0);
        chk({tag, "_req_cycles"}, reqc, in.mem_en ? a_dly + 1 : 0);
        if (in.mem_en) begin
            chk({tag, "_bus_fields"}, bus_bad, 32'h0);
            chk({tag, "_wait_wb"}, wait_bad, 32'h0);
        end
        chk({tag, "_wb_we"}, {31'h0, wb_rf_we}, {31'h0, in.rf_we});
        chk({tag, "_wb_waddr"}, {27'h0, wb_rf_waddr}, {27'h0, in.waddr});
        chk({tag, "_wb_pc"}, wb_pc, in.pc);
        chk({tag, "_wb_wdata"}, wb_rf_wdata, exp_wd);
        chk({tag, "_fwd"}, {fwd_we, fwd_waddr, fwd_load_pending}, {in.rf_we, in.waddr, 1'b0});
        chk({tag, "_fwd_wdata"}, fwd_wdata, exp_wd);
    endtask

    initial begin
        instr_t t;
        logic [31:0] held;
        int hold_req;
        logic [4:0] legal [7] = '{5'h0F, 5'h0C, 5'h03, 5'h08, 5'h04, 5'h02, 5'h01};

        resetn = 1'b0; stall = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        t = '0; drive_ex(t);
        #12;
        check_zero("reset");
        @(posedge clk); #1;
        resetn = 1'b1;

        t = '0; t.pc = 32'h40; t.rf_we = 1'b1; t.waddr = 5'd5; t.result = 32'h1234;
        issue("alu", t, 0, 0, 32'h0, 1'b0);

        t = '0; t.pc = 32'h44; t.mem_en = 1'b1; t.addr = 32'h100; t.sel = 5'b01111;
        t.rf_we = 1'b1; t.waddr = 5'd6; t.result = 32'h5555;
        issue("lw", t, 0, 0, 32'hDEADBEEF, 1'b0);

        t.pc = 32'h48; t.addr = 32'h103; t.sel = 5'b10001; t.waddr = 5'd7;
        issue("lb", t, 1, 1, 32'h80FFFFFF, 1'b1);

        t.pc = 32'h4C; t.addr = 32'h102; t.sel = 5'b00011; t.waddr = 5'd8;
        issue("lhu", t, 0, 2, 32'h80011234, 1'b0);

        t = '0; t.pc = 32'h50; t.mem_en = 1'b1; t.wen = 4'b0100; t.addr = 32'h205;
        t.wdata = 32'h00AB0000; t.result = 32'h77;
        issue("sw", t, 2, 2, 32'h0, 1'b1);

        // Load completes, then sits in DONE under a MEM hold with a stray data_ok.
        t = '0; t.pc = 32'h54; t.mem_en = 1'b1; t.addr = 32'h300; t.sel = 5'b11100;
        t.rf_we = 1'b1; t.waddr = 5'd9;
        issue("hold_ld", t, 0, 0, 32'h1234F00D, 1'b0);
        held = model_load(32'h1234F00D, 5'b11100);
        t.pc = 32'h58; t.wen = 4'b1111;
        drive_ex(t);
        stall = 6'b011000; data_data_ok = 1'b1;
        hold_req = 0;
        for (int i = 0; i < 4; i++) begin
            data_rdata = $urandom;
            if (data_req) hold_req++;
            chk("hold_pending", {31'h0, fwd_load_pending}, 32'h0);
            chk("hold_wdata", wb_rf_wdata, held);
            @(posedge clk); #1;
        end
        chk("hold_req_count", hold_req, 32'h0);
        chk("hold_stallreq", {31'h0, stallreq_for_mem}, 32'h0);
        data_data_ok = 1'b0;
        stall = 6'b001000;
        @(posedge clk); #1;
        chk("bubble_we", {31'h0, wb_rf_we}, 32'h0);
        chk("bubble_pc", wb_pc, 32'h0);
        stall = 6'b000000; t = '0; drive_ex(t);

        // Reset while waiting in RESP, then a stray data_ok in IDLE.
        t = '0; t.pc = 32'h60; t.mem_en = 1'b1; t.addr = 32'h400; t.sel = 5'b01111;
        t.rf_we = 1'b1; t.waddr = 5'd10; t.result = 32'h99;
        drive_ex(t);
        @(posedge clk); #1;
        t = '0; drive_ex(t);
        stall = 6'b011111; data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        chk("resp_stallreq", {31'h0, stallreq_for_mem}, 32'h1);
        chk("resp_req", {31'h0, data_req}, 32'h0);
        #2 resetn = 1'b0;
        #1 check_zero("async_rst");
        @(posedge clk); #1;
        resetn = 1'b1;
        data_data_ok = 1'b1; data_rdata = 32'hCAFEBABE;
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        check_zero("stray_ok");
        stall = 6'b000000;

        for (int n = 0; n < 40; n++) begin
            int kind = $urandom_range(0, 2);
            t.pc = $urandom; t.addr = $urandom; t.wdata = $urandom; t.result = $urandom;
            t.rf_we = 1'($urandom_range(0, 1)); t.waddr = 5'($urandom);
            t.sel = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                  : {1'($urandom_range(0, 1)), legal[$urandom_range(0, 6)][3:0]};
            t.mem_en = (kind != 0);
            t.wen = (kind == 2) ? 4'($urandom_range(1, 15)) : 4'b0000;
            issue($sformatf("rnd%0d", n), t, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
